serial_subtractor: RTL

Bit-serial subtractor that computes A − B one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the arithmetic inverse of the lab half-adder datapath: it consumes two parallel operands, runs them serially through the cell, and returns a parallel difference with a final borrow. It sits behind the board switches (operands) and drives the LED outputs (difference, borrow, status), and is controlled by a start/busy/done handshake.

---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first through one full-subtractor
// cell and a borrow flop, returning a parallel difference and final borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   d_sr_q, d_sr_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cell_x_c, cell_y_c, cell_d_c, cell_bout_c;

  // Full-subtractor cell on the current LSBs and the stored borrow
  always_comb begin
    cell_x_c    = a_sr_q[0];
    cell_y_c    = b_sr_q[0];
    cell_d_c    = cell_x_c ^ cell_y_c ^ borrow_q;
    cell_bout_c = (~cell_x_c & cell_y_c) | (~(cell_x_c ^ cell_y_c) & borrow_q);
  end

  // Next-state, datapath and output decode; busy/done follow the next state
  // so they are registered alongside it
  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    d_sr_d       = d_sr_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          d_sr_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        d_sr_d   = {cell_d_c, d_sr_q[WIDTH-1:1]};
        borrow_d = cell_bout_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d       = {cell_d_c, d_sr_q[WIDTH-1:1]};
          borrow_out_d = cell_bout_c;
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      d_sr_q       <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      d_sr_q       <= d_sr_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
